// File: rtl/scr_pkg.sv
// Shared scrambler/descrambler constants and the tap feedback helper.
package scr_pkg;

    localparam int              SCR_LEN  = 7;
    localparam logic [6:0]      SCR_TAPS = 7'b110_0000;
    localparam int              SCR_W    = 32;

    // Callers zero-extend to SCR_W so one function serves any LEN up to 32.
    function automatic logic scr_fb(input logic [SCR_W-1:0] sr, input logic [SCR_W-1:0] taps);
        return ^(sr & taps);
    endfunction

endpackage

// File: rtl/scr_shift_reg.sv
// LEN-bit serial-in shift register; bit i holds the input delayed i+1 cycles.
module scr_shift_reg #(
    parameter int LEN = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din,
    output logic [LEN-1:0] sr
);

    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[LEN-2:0], din};
    end

endmodule

// File: rtl/data_decrypt_core.sv
// Self-synchronising multiplicative descrambler: one plaintext bit per clock.
module data_decrypt_core
    import scr_pkg::*;
#(
    parameter int             LEN  = SCR_LEN,
    parameter logic [LEN-1:0] TAPS = SCR_TAPS
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_code,
    output logic o_data,
    output logic o_sync
);

    localparam int CW = $clog2(LEN + 1);

    logic [LEN-1:0] sr;
    logic [CW-1:0]  fill;

    // History holds received code, not plaintext, so a bad bit only lives LEN cycles.
    scr_shift_reg #(.LEN(LEN)) u_sr (
        .clk (i_clk),
        .rst (i_rst),
        .din (i_code),
        .sr  (sr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= 1'b0;
            o_sync <= 1'b0;
            fill   <= '0;
        end else begin
            o_data <= i_code ^ scr_fb(SCR_W'(sr), SCR_W'(TAPS));
            if (fill != CW'(LEN))     fill   <= fill + CW'(1);
            if (fill == CW'(LEN - 1)) o_sync <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_decrypt_core.sv
// Scoreboard bench for data_decrypt_core with a behavioural encryptor for loopback.
module tb_data_decrypt_core;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_code = 1'b0;
    logic o_data, o_sync;

    int total = 0;
    int bad   = 0;

    bit       exp_q[$];
    bit [6:0] sre;
    localparam bit [6:0] TAPS = 7'b110_0000;

    data_decrypt_core dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_code (i_code),
        .o_data (o_data),
        .o_sync (o_sync)
    );

    always #5 i_clk = ~i_clk;

    // Drive one bit, clock it, settle past the edge.
    task automatic step(input bit code, input bit rst);
        i_code = code;
        i_rst  = rst;
        @(posedge i_clk);
        #1;
    endtask

    // Encryptor: c = d ^ fb(sre), sre shifts in its own code output.
    function automatic bit enc(input bit d);
        bit c;
        c   = d ^ (^(sre & TAPS));
        sre = {sre[5:0], c};
        return c;
    endfunction

    task automatic pop_check(input string name, input int idx);
        bit e;
        e = exp_q.pop_front();
        total++;
        if (o_data !== e) begin
            bad++;
            $display("FAIL %s bit=%0d o_data=%b expected=%b", name, idx, o_data, e);
        end
    endtask

    task automatic reset_both();
        sre = '0;
        exp_q.delete();
        step(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1);
            total++;
            if (o_data !== 1'b0 || o_sync !== 1'b0) begin
                bad++;
                $display("FAIL reset cyc=%0d data=%b sync=%b expected 0/0", i, o_data, o_sync);
            end
            total++;
            if (dut.u_sr.sr !== 7'd0) begin
                bad++;
                $display("FAIL reset_sr cyc=%0d sr=%b expected 0", i, dut.u_sr.sr);
            end
        end
    endtask

    task automatic test_impulse();
        reset_both();
        for (int j = 0; j < 16; j++) begin
            exp_q.push_back(j == 3 || j == 9 || j == 10);
            step(j == 3, 1'b0);
            pop_check("impulse", j);
        end
    endtask

    task automatic test_sync();
        reset_both();
        for (int i = 1; i <= 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            total++;
            if (o_sync !== (i >= 7)) begin
                bad++;
                $display("FAIL sync bit=%0d o_sync=%b expected=%b", i, o_sync, i >= 7);
            end
        end
    endtask

    task automatic test_loopback_midreset();
        bit d, c;
        int early_bad;
        reset_both();
        for (int n = 0; n < 1000; n++) begin
            d = 1'($urandom_range(0, 1));
            c = enc(d);
            if (n == 500) begin
                step(c, 1'b1);
                total++;
                if (o_data !== 1'b0 || o_sync !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset data=%b sync=%b expected 0/0", o_data, o_sync);
                end
            end else if (n > 500 && n <= 507) begin
                step(c, 1'b0);
                if (o_data !== d) early_bad++;
                total++;
                if (o_sync !== (n == 507)) begin
                    bad++;
                    $display("FAIL resync bit=%0d o_sync=%b expected=%b", n, o_sync, n == 507);
                end
            end else begin
                exp_q.push_back(d);
                step(c, 1'b0);
                pop_check("loopback", n);
            end
        end
        total++;
        if (early_bad > 7) begin
            bad++;
            $display("FAIL resync_errors got=%0d max=7", early_bad);
        end
    endtask

    task automatic test_error_inject();
        bit d, c;
        reset_both();
        for (int n = 0; n < 40; n++) begin
            d = 1'($urandom_range(0, 1));
            c = enc(d);
            exp_q.push_back(d ^ (n == 20 || n == 26 || n == 27));
            step(n == 20 ? ~c : c, 1'b0);
            pop_check("errinj", n);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_sync();
        test_loopback_midreset();
        test_error_inject();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
